soc_addr_decoder: RTL and testbench

SOC_ADDR_DECODER -- requirements
Module: soc_addr_decoder

---
 rtl/soc_addr_decoder_pkg.sv | 40 ++++
 rtl/soc_addr_rule_match.sv | 17 +
 rtl/soc_addr_decoder.sv | 164 ++++++++++++++++
 tb/tb_soc_addr_decoder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/soc_addr_decoder_pkg.sv
// Shared types and the power-on address map for the SoC address decoder.
// Rule fields are stored at 64 bits; the decoder uses the low AddrWidth bits.
package soc_addr_decoder_pkg;

  localparam int unsigned MaxAddrWidth   = 64;
  localparam int unsigned NrDefaultRules = 10;

  // Bit positions inside the 3-bit attribute word {exec, cached, valid}
  localparam int unsigned AttrValid  = 0;
  localparam int unsigned AttrCached = 1;
  localparam int unsigned AttrExec   = 2;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] base;
    logic [MaxAddrWidth-1:0] len;
    logic                    valid;
    logic                    cached;
    logic                    exec;
  } rule_t;

  function automatic rule_t default_rule(input int unsigned idx);
    rule_t r;
    r = '0;
    case (idx)
      0: r = '{base: 64'h8000_0000, len: 64'h4000_0000, valid: 1'b1, cached: 1'b1, exec: 1'b1}; // DRAM
      1: r = '{base: 64'h4000_0000, len: 64'h0000_1000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // GPIO
      2: r = '{base: 64'h3000_0000, len: 64'h0001_0000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // Ethernet
      3: r = '{base: 64'h2000_0000, len: 64'h0080_0000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // SPI
      4: r = '{base: 64'h1800_0000, len: 64'h0000_1000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // Timer
      5: r = '{base: 64'h1000_0000, len: 64'h0000_1000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // UART
      6: r = '{base: 64'h0C00_0000, len: 64'h0400_0000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // PLIC
      7: r = '{base: 64'h0200_0000, len: 64'h000C_0000, valid: 1'b1, cached: 1'b0, exec: 1'b0}; // CLINT
      8: r = '{base: 64'h0001_0000, len: 64'h0001_0000, valid: 1'b1, cached: 1'b0, exec: 1'b1}; // ROM
      9: r = '{base: 64'h0000_0000, len: 64'h0000_1000, valid: 1'b1, cached: 1'b0, exec: 1'b1}; // Debug
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/soc_addr_rule_match.sv
// Combinational single-rule address comparison; a zero-length rule never matches.
module soc_addr_rule_match #(
  parameter int unsigned AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [AddrWidth-1:0] base_i,
  input  logic [AddrWidth-1:0] len_i,
  input  logic                 valid_i,
  output logic                 match_o
);

  logic [AddrWidth-1:0] offset;

  assign offset  = addr_i - base_i;
  assign match_o = valid_i && (len_i != '0) && (addr_i >= base_i) && (offset < len_i);

endmodule

// File: rtl/soc_addr_decoder.sv
// Registered, lowest-index-wins address decoder with a lockable rule table.
// Optional miss counter on err_cnt_o is built when SOC_ADDR_DECODER_ERR_CNT_EN is defined.
module soc_addr_decoder
  import soc_addr_decoder_pkg::*;
#(
  parameter int unsigned NrRules   = 10,
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned CntWidth  = 16,
  localparam int unsigned IdxW     = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_exec_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_hit_o,
  output logic [IdxW-1:0]      rsp_idx_o,
  output logic                 rsp_cached_o,
  output logic                 rsp_exec_err_o,
  input  logic                 cfg_we_i,
  input  logic [IdxW-1:0]      cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 locked_o,
  output logic                 err_sticky_o,
  input  logic                 err_clr_i
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
  ,
  output logic [CntWidth-1:0]  err_cnt_o
`endif
);

  if (NrRules < 1 || NrRules > 32 || AddrWidth < 1 || AddrWidth > MaxAddrWidth || CntWidth < 1)
  begin : g_bad_param
    $error("soc_addr_decoder: parameter out of range");
  end

  rule_t              rules_q [NrRules];
  logic [NrRules-1:0] match;

  logic            lk_hit, lk_cached, lk_exec_err;
  logic [IdxW-1:0] lk_idx;
  logic            req_accept, miss, cfg_write;

  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_hit_q, rsp_hit_d;
  logic [IdxW-1:0] rsp_idx_q, rsp_idx_d;
  logic            rsp_cached_q, rsp_cached_d;
  logic            rsp_exec_err_q, rsp_exec_err_d;
  logic            locked_q, locked_d;
  logic            err_sticky_q, err_sticky_d;

  for (genvar g = 0; g < NrRules; g++) begin : g_rule
    soc_addr_rule_match #(.AddrWidth(AddrWidth)) u_match (
      .addr_i  (req_addr_i),
      .base_i  (rules_q[g].base[AddrWidth-1:0]),
      .len_i   (rules_q[g].len[AddrWidth-1:0]),
      .valid_i (rules_q[g].valid),
      .match_o (match[g])
    );
  end

  // Scan from the top so the lowest matching index is the one that sticks.
  always_comb begin
    lk_hit    = 1'b0;
    lk_idx    = '0;
    lk_cached = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match[i]) begin
        lk_hit    = 1'b1;
        lk_idx    = IdxW'(i);
        lk_cached = rules_q[i].cached;
      end
    end
    lk_exec_err = req_exec_i;
    for (int i = 0; i < NrRules; i++) begin
      if (lk_hit && (lk_idx == IdxW'(i))) lk_exec_err = req_exec_i && !rules_q[i].exec;
    end
  end

  assign req_ready_o = !rsp_valid_q || rsp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;
  assign miss        = req_accept && !lk_hit;
  assign cfg_write   = cfg_we_i && !locked_q && (32'(cfg_idx_i) < NrRules);

  always_comb begin
    rsp_valid_d    = rsp_valid_q;
    rsp_hit_d      = rsp_hit_q;
    rsp_idx_d      = rsp_idx_q;
    rsp_cached_d   = rsp_cached_q;
    rsp_exec_err_d = rsp_exec_err_q;
    if (req_accept) begin
      rsp_valid_d    = 1'b1;
      rsp_hit_d      = lk_hit;
      rsp_idx_d      = lk_idx;
      rsp_cached_d   = lk_cached;
      rsp_exec_err_d = lk_exec_err;
    end else if (rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
    locked_d     = locked_q || cfg_lock_i;
    err_sticky_d = miss || (err_sticky_q && !err_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q    <= 1'b0;
      rsp_hit_q      <= 1'b0;
      rsp_idx_q      <= '0;
      rsp_cached_q   <= 1'b0;
      rsp_exec_err_q <= 1'b0;
      locked_q       <= 1'b0;
      err_sticky_q   <= 1'b0;
      for (int i = 0; i < NrRules; i++) rules_q[i] <= default_rule(unsigned'(i));
    end else begin
      rsp_valid_q    <= rsp_valid_d;
      rsp_hit_q      <= rsp_hit_d;
      rsp_idx_q      <= rsp_idx_d;
      rsp_cached_q   <= rsp_cached_d;
      rsp_exec_err_q <= rsp_exec_err_d;
      locked_q       <= locked_d;
      err_sticky_q   <= err_sticky_d;
      if (cfg_write) begin
        rules_q[cfg_idx_i] <= '{base:   MaxAddrWidth'(cfg_base_i),
                                len:    MaxAddrWidth'(cfg_len_i),
                                valid:  cfg_attr_i[AttrValid],
                                cached: cfg_attr_i[AttrCached],
                                exec:   cfg_attr_i[AttrExec]};
      end
    end
  end

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_hit_o      = rsp_hit_q;
  assign rsp_idx_o      = rsp_idx_q;
  assign rsp_cached_o   = rsp_cached_q;
  assign rsp_exec_err_o = rsp_exec_err_q;
  assign locked_o       = locked_q;
  assign err_sticky_o   = err_sticky_q;

`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
  logic [CntWidth-1:0] err_cnt_q, err_cnt_d;

  // A clear coinciding with a miss keeps that miss in the count.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr_i)                  err_cnt_d = miss ? CntWidth'(1) : '0;
    else if (miss && !(&err_cnt_q)) err_cnt_d = err_cnt_q + CntWidth'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_soc_addr_decoder.sv
// Directed scoreboard bench for soc_addr_decoder; counter checks need SOC_ADDR_DECODER_ERR_CNT_EN.
module tb_soc_addr_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_exec;
  logic [63:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_hit, rsp_cached, rsp_exec_err;
  logic [3:0]  rsp_idx;
  logic        cfg_we, cfg_lock, locked, err_sticky, err_clr;
  logic [3:0]  cfg_idx;
  logic [63:0] cfg_base, cfg_len;
  logic [2:0]  cfg_attr;
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  always #5 clk = ~clk;

  soc_addr_decoder dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_addr_i(req_addr), .req_exec_i(req_exec),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_hit_o(rsp_hit), .rsp_idx_o(rsp_idx),
    .rsp_cached_o(rsp_cached), .rsp_exec_err_o(rsp_exec_err),
    .cfg_we_i(cfg_we), .cfg_idx_i(cfg_idx),
    .cfg_base_i(cfg_base), .cfg_len_i(cfg_len), .cfg_attr_i(cfg_attr),
    .cfg_lock_i(cfg_lock), .locked_o(locked),
    .err_sticky_o(err_sticky), .err_clr_i(err_clr)
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
    logic       cached;
    logic       exec_err;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responses are compared whenever the bench consumes one.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL rsp_unexpected: observed=%0h expected=none",
               {rsp_hit, rsp_idx, rsp_cached, rsp_exec_err});
      end else begin
        cur = sb.pop_front();
        check("rsp", 64'({rsp_hit, rsp_idx, rsp_cached, rsp_exec_err}), 64'(cur));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] a, input logic ex, input logic h,
                      input logic [3:0] ix, input logic c, input logic ee);
    int n;
    n = 0;
    req_addr  = a;
    req_exec  = ex;
    req_valid = 1'b1;
    sb.push_back({h, ix, c, ee});
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed=ready_low expected=ready_high addr=%0h", a);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] ix, input logic [63:0] b,
                           input logic [63:0] l, input logic [2:0] at);
    cfg_we = 1'b1; cfg_idx = ix; cfg_base = b; cfg_len = l; cfg_attr = at;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_exec = 1'b0; rsp_ready = 1'b1;
    cfg_we = 1'b0; cfg_idx = '0; cfg_base = '0; cfg_len = '0; cfg_attr = '0;
    cfg_lock = 1'b0; err_clr = 1'b0;
    #12;
    check("rst_rsp_valid", 64'(rsp_valid), 0);
    check("rst_req_ready", 64'(req_ready), 1);
    check("rst_locked", 64'(locked), 0);
    check("rst_sticky", 64'(err_sticky), 0);
    check("rst_rsp_fields", 64'({rsp_hit, rsp_idx, rsp_cached, rsp_exec_err}), 0);
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
    check("rst_cnt", 64'(err_cnt), 0);
`endif
    @(negedge clk); rst = 1'b0;
    tick();

    send(64'h8000_0000, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0);
    send(64'hBFFF_FFFF, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    check("sticky_after_hits", 64'(err_sticky), 0);
    send(64'hC000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("sticky_after_miss", 64'(err_sticky), 1);
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
    check("cnt_after_miss", 64'(err_cnt), 1);
`endif
    send(64'h1000_0008, 1'b1, 1'b1, 4'd5, 1'b0, 1'b1);
    send(64'h0001_0004, 1'b1, 1'b1, 4'd8, 1'b0, 1'b0);
    send(64'h0000_0FFF, 1'b1, 1'b1, 4'd9, 1'b0, 1'b0);
    send(64'hC000_0000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1);

    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("sticky_cleared", 64'(err_sticky), 0);
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
    check("cnt_cleared", 64'(err_cnt), 0);
`endif
    err_clr = 1'b1;
    send(64'hFFFF_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("sticky_clr_with_miss", 64'(err_sticky), 1);
`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
    check("cnt_clr_with_miss", 64'(err_cnt), 1);
`endif

    // Backpressure: A held for three cycles while B waits.
    tick();
    rsp_ready = 1'b0;
    send(64'h4000_0010, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    req_addr = 64'h3000_0020; req_exec = 1'b0; req_valid = 1'b1;
    sb.push_back({1'b1, 4'd2, 1'b0, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_req_ready", 64'(req_ready), 0);
      check("stall_rsp_valid", 64'(rsp_valid), 1);
      check("stall_rsp_hold", 64'({rsp_hit, rsp_idx, rsp_cached, rsp_exec_err}), 64'(7'b1_0001_0_0));
    end
    @(posedge clk); #1; rsp_ready = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0;
    tick();
    check("stall_sb_drained", 64'(sb.size()), 0);

    // Write in the same cycle as a lookup: lookup sees the old table.
    cfg_we = 1'b1; cfg_idx = 4'd5; cfg_base = 64'h1000_0000; cfg_len = 64'h0; cfg_attr = 3'b001;
    send(64'h1000_0000, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    cfg_we = 1'b0;
    send(64'h1000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    cfg_write(4'd3, 64'h5000_0000, 64'h100, 3'b011);
    cfg_write(4'd4, 64'h5000_0000, 64'h1000, 3'b101);
    send(64'h5000_0010, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
    send(64'h5000_00FF, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    send(64'h5000_0100, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0);
    cfg_write(4'd12, 64'hC000_0000, 64'h100, 3'b001);
    send(64'hC000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);

    cfg_lock = 1'b1; tick(); cfg_lock = 1'b0;
    check("locked_set", 64'(locked), 1);
    cfg_write(4'd5, 64'h1000_0000, 64'h1000, 3'b001);
    send(64'h1000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("locked_holds", 64'(locked), 1);

`ifdef SOC_ADDR_DECODER_ERR_CNT_EN
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    for (int i = 0; i < 65539; i++) send(64'hC000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    check("cnt_saturated", 64'(err_cnt), 64'hFFFF);
    err_clr = 1'b1;
    send(64'hC000_0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("cnt_clr_after_sat", 64'(err_cnt), 1);
`endif

    // Reset with a response stuck in the output register.
    tick();
    rsp_ready = 1'b0;
    send(64'h8000_0000, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);
    #2; rst = 1'b1;
    #1;
    check("inflight_rsp_valid", 64'(rsp_valid), 0);
    check("inflight_rsp_fields", 64'({rsp_hit, rsp_idx, rsp_cached, rsp_exec_err}), 0);
    check("inflight_req_ready", 64'(req_ready), 1);
    check("inflight_locked", 64'(locked), 0);
    check("inflight_sticky", 64'(err_sticky), 0);
    sb.delete();
    @(negedge clk); rst = 1'b0;
    tick();
    rsp_ready = 1'b1;
    send(64'h1000_0008, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0);
    tick();
    tick();
    check("final_sb_drained", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
